// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_WORD_WIDTH      = 32;
  localparam int unsigned DEF_WORDS_PER_BLOCK = 16;
  localparam int unsigned DEF_NSETS           = 128;
  localparam int unsigned DEF_NWAYS           = 4;

  function automatic int unsigned off_bits(input int unsigned word_width,
                                           input int unsigned words_per_block);
    return $clog2(word_width / 8) + $clog2(words_per_block);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned nsets);
    return $clog2(nsets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_width,
                                           input int unsigned word_width,
                                           input int unsigned words_per_block,
                                           input int unsigned nsets);
    return addr_width - idx_bits(nsets) - off_bits(word_width, words_per_block);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU helper: victim choice from valid/age and next ages after touching one way.
module cache_lru #(
  parameter int unsigned NWAYS = 4,
  localparam int unsigned WAYW = $clog2(NWAYS)
) (
  input  logic [NWAYS-1:0]           valid,
  input  logic [NWAYS-1:0][WAYW-1:0] age,
  input  logic [WAYW-1:0]            acc_way,
  output logic [WAYW-1:0]            victim,
  output logic [NWAYS-1:0][WAYW-1:0] next_age
);

  logic            found;
  logic [WAYW-1:0] acc_age;

  // Oldest way is the fallback; any invalid way (lowest index first) overrides it.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NWAYS; i++) begin
      if (age[i] == WAYW'(NWAYS - 1)) victim = WAYW'(i);
    end
    for (int unsigned i = 0; i < NWAYS; i++) begin
      if (!found && !valid[i]) begin
        victim = WAYW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    next_age = age;
    acc_age  = age[acc_way];
    for (int unsigned i = 0; i < NWAYS; i++) begin
      if (WAYW'(i) == acc_way) next_age[i] = '0;
      else if (age[i] < acc_age) next_age[i] = age[i] + WAYW'(1);
    end
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned NSETS           = DEF_NSETS,
  parameter int unsigned NWAYS           = DEF_NWAYS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cpu_req,
  input  logic                                  cpu_we,
  input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
  input  logic [WORD_WIDTH/8-1:0]               cpu_be,
  input  logic [WORD_WIDTH-1:0]                 cpu_wdata,
  output logic                                  cpu_ready,
  output logic                                  cpu_resp_valid,
  output logic                                  cpu_hit,
  output logic [WORD_WIDTH-1:0]                 cpu_rdata,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic                                  mem_ack,
  input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata,
  output logic [31:0]                           hit_cnt,
  output logic [31:0]                           miss_cnt
);

  localparam int unsigned WB   = WORD_WIDTH / 8;
  localparam int unsigned BSEL = $clog2(WB);
  localparam int unsigned OFF  = off_bits(WORD_WIDTH, WORDS_PER_BLOCK);
  localparam int unsigned IDX  = idx_bits(NSETS);
  localparam int unsigned TAG  = tag_bits(ADDR_WIDTH, WORD_WIDTH, WORDS_PER_BLOCK, NSETS);
  localparam int unsigned WAYW = $clog2(NWAYS);
  localparam int unsigned BLK  = WORD_WIDTH * WORDS_PER_BLOCK;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [WB-1:0]         req_be;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic [WAYW-1:0]       victim_q;
  logic                  hit_q;
  logic [WORD_WIDTH-1:0] rdata_q;

  logic [NWAYS-1:0]            valid_q [NSETS];
  logic [NWAYS-1:0]            dirty_q [NSETS];
  logic [NWAYS-1:0][WAYW-1:0]  age_q   [NSETS];
  logic [TAG-1:0]              tag_q   [NSETS][NWAYS];
  logic [BLK-1:0]              data_q  [NSETS][NWAYS];

  logic [IDX-1:0]        idx;
  logic [TAG-1:0]        req_tag;
  logic [OFF-BSEL-1:0]   wsel;
  logic                  hit;
  logic [WAYW-1:0]       hit_way, victim, acc_way;
  logic [NWAYS-1:0][WAYW-1:0] next_age;
  logic [BLK-1:0]        hit_blk, vic_blk, fill_blk;
  logic [WORD_WIDTH-1:0] hit_word, fill_word;
  logic                  unused_ok;

  assign idx       = req_addr[OFF +: IDX];
  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG];
  assign wsel      = req_addr[BSEL +: OFF-BSEL];
  assign unused_ok = ^req_addr[BSEL-1:0];

  function automatic logic [BLK-1:0] merge(input logic [BLK-1:0]        blk,
                                           input logic [OFF-BSEL-1:0]   sel,
                                           input logic [WB-1:0]         be,
                                           input logic [WORD_WIDTH-1:0] wd);
    logic [BLK-1:0] r;
    r = blk;
    for (int unsigned b = 0; b < WB; b++) begin
      if (be[b]) r[32'(sel) * WORD_WIDTH + b * 8 +: 8] = wd[b * 8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned i = 0; i < NWAYS; i++) begin
      if (valid_q[idx][i] && tag_q[idx][i] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAYW'(i);
      end
    end
  end

  assign hit_blk   = data_q[idx][hit_way];
  assign vic_blk   = data_q[idx][victim_q];
  assign hit_word  = hit_blk[32'(wsel) * WORD_WIDTH +: WORD_WIDTH];
  assign fill_word = mem_rdata[32'(wsel) * WORD_WIDTH +: WORD_WIDTH];
  assign fill_blk  = req_we ? merge(mem_rdata, wsel, req_be, req_wdata) : mem_rdata;
  assign acc_way   = (state_q == LOOKUP) ? hit_way : victim_q;

  cache_lru #(.NWAYS(NWAYS)) u_lru (
    .valid    (valid_q[idx]),
    .age      (age_q[idx]),
    .acc_way  (acc_way),
    .victim   (victim),
    .next_age (next_age)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_hit        = 1'b0;
    cpu_rdata      = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) state_d = RESPOND;
        else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = WRITEBACK;
        else state_d = REFILL;
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx][victim_q], idx, OFF'(0)};
        mem_wdata = vic_blk;
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, OFF'(0)};
        if (mem_ack) state_d = RESPOND;
      end
      RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_hit        = hit_q;
        cpu_rdata      = rdata_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset has priority over every install so an aborted miss leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned w = 0; w < NWAYS; w++) age_q[s][w] <= WAYW'(w);
      end
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_be    <= '0;
      req_wdata <= '0;
      victim_q  <= '0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          req_addr  <= cpu_addr;
          req_we    <= cpu_we;
          req_be    <= cpu_be;
          req_wdata <= cpu_wdata;
        end
        LOOKUP: begin
          hit_q <= hit;
          if (hit) begin
            age_q[idx] <= next_age;
            rdata_q    <= req_we ? '0 : hit_word;
            if (req_we) dirty_q[idx][hit_way] <= 1'b1;
          end else begin
            victim_q <= victim;
          end
        end
        REFILL: if (mem_ack) begin
          valid_q[idx][victim_q] <= 1'b1;
          dirty_q[idx][victim_q] <= req_we;
          age_q[idx]             <= next_age;
          rdata_q                <= req_we ? '0 : fill_word;
        end
        RESPOND: begin
          if (hit_q) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == LOOKUP && hit && req_we)
        data_q[idx][hit_way] <= merge(hit_blk, wsel, req_be, req_wdata);
      if (state_q == REFILL && mem_ack) begin
        data_q[idx][victim_q] <= fill_blk;
        tag_q[idx][victim_q]  <= req_tag;
      end
    end
  end

endmodule
